// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage and its neighbours: hazard/branch
// control and instruction-memory data in, fetch address and IF/ID contents out.
interface fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [5:0]  branch_target;
    logic [15:0] instr;
    logic [5:0]  pc;
    logic [15:0] ifid_instr;
    logic [5:0]  ifid_pc;
    logic        ifid_valid;
    logic [15:0] fetch_cnt;

    modport master (
        input  stall, branch_taken, branch_target, instr,
        output pc, ifid_instr, ifid_pc, ifid_valid, fetch_cnt
    );

    modport slave (
        output stall, branch_taken, branch_target, instr,
        input  pc, ifid_instr, ifid_pc, ifid_valid, fetch_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall and branch redirect.
// Define FETCH_BRANCH_FLUSH_EN to squash the wrong-path instruction on a taken branch.
module fetch_stage (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master fif
);
    localparam logic [15:0] NOP_WORD = 16'hF000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  pc_r;
    logic [15:0] ifid_instr_r;
    logic [5:0]  ifid_pc_r;
    logic        ifid_valid_r;
    logic [15:0] fetch_cnt_r;
    logic [5:0]  pc_inc_s;

    // PC+1 wraps naturally in 6 bits
    assign pc_inc_s = pc_r + 6'd1;

    // Fetch FSM with PC, IF/ID and counter all held in registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= BOOT;
            pc_r         <= 6'd0;
            ifid_instr_r <= NOP_WORD;
            ifid_pc_r    <= 6'd0;
            ifid_valid_r <= 1'b0;
            fetch_cnt_r  <= 16'd0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r <= RUN;
                end
                RUN, HOLD: begin
                    if (fif.branch_taken) begin
                        state_r <= RUN;
                        pc_r    <= fif.branch_target;
`ifdef FETCH_BRANCH_FLUSH_EN
                        ifid_instr_r <= NOP_WORD;
                        ifid_valid_r <= 1'b0;
`else
                        // delay slot: the instruction behind the branch still issues
                        ifid_instr_r <= fif.instr;
                        ifid_pc_r    <= pc_inc_s;
                        ifid_valid_r <= 1'b1;
                        fetch_cnt_r  <= fetch_cnt_r + 16'd1;
`endif
                    end else if (fif.stall) begin
                        state_r <= HOLD;
                    end else begin
                        state_r      <= RUN;
                        pc_r         <= pc_inc_s;
                        ifid_instr_r <= fif.instr;
                        ifid_pc_r    <= pc_inc_s;
                        ifid_valid_r <= 1'b1;
                        fetch_cnt_r  <= fetch_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= BOOT;
                end
            endcase
        end
    end

    assign fif.pc         = pc_r;
    assign fif.ifid_instr = ifid_instr_r;
    assign fif.ifid_pc    = ifid_pc_r;
    assign fif.ifid_valid = ifid_valid_r;
    assign fif.fetch_cnt  = fetch_cnt_r;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, hand-written corner sequences and
// randomized traffic, all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;
    localparam logic [15:0] NOP = 16'hF000;
`ifdef FETCH_BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] mem [16];
    int checks = 0;
    int errors = 0;

    fetch_stage_if fif ();
    fetch_stage dut (.CLK(clk), .RST(rst), .fif(fif));

    always #5 clk = ~clk;
    assign fif.instr = mem[fif.pc[3:0]];

    // reference model state
    logic [5:0]  m_pc = 6'd0;
    logic [15:0] m_instr = NOP;
    logic [5:0]  m_ifpc = 6'd0;
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    bit          m_boot = 1'b1;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [5:0]  pc;
        logic [15:0] instr;
        logic [5:0]  ifpc;
        logic        valid;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic b, input logic [5:0] t);
        logic [15:0] fetched;
        fetched = mem[m_pc[3:0]];
        if (r) begin
            m_pc = 6'd0; m_instr = NOP; m_ifpc = 6'd0; m_valid = 1'b0; m_cnt = 16'd0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (b || !s) begin
            if (b && FLUSH) begin
                m_instr = NOP;
                m_valid = 1'b0;
            end else begin
                m_instr = fetched;
                m_ifpc  = 6'((int'(m_pc) + 1) % 64);
                m_valid = 1'b1;
                m_cnt   = 16'((int'(m_cnt) + 1) % 65536);
            end
            m_pc = b ? t : 6'((int'(m_pc) + 1) % 64);
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic b, input logic [5:0] t);
        rst = r;
        fif.stall = s;
        fif.branch_taken = b;
        fif.branch_target = t;
        @(posedge clk);
        model_edge(r, s, b, t);
        #1;
        chk("pc", {10'd0, fif.pc}, {10'd0, m_pc});
        chk("ifid_instr", fif.ifid_instr, m_instr);
        chk("ifid_pc", {10'd0, fif.ifid_pc}, {10'd0, m_ifpc});
        chk("ifid_valid", {15'd0, fif.ifid_valid}, {15'd0, m_valid});
        chk("fetch_cnt", fif.fetch_cnt, m_cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 6'd0);
    endtask

    initial begin
        bit seen63;
        bit wrapped;
        fif.stall = 1'b0;
        fif.branch_taken = 1'b0;
        fif.branch_target = 6'd0;
        for (int i = 0; i < 16; i++) mem[i] = NOP;
        mem[0] = 16'h2213;

        // reset, boot, run to PC=5, stall three edges, resume
        tbl[0]  = '{1'b1, 1'b0, 6'd0, NOP,      6'd0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 6'd0, NOP,      6'd0, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 6'd1, 16'h2213, 6'd1, 1'b1, 16'd1};
        tbl[3]  = '{1'b0, 1'b0, 6'd2, NOP,      6'd2, 1'b1, 16'd2};
        tbl[4]  = '{1'b0, 1'b0, 6'd3, NOP,      6'd3, 1'b1, 16'd3};
        tbl[5]  = '{1'b0, 1'b0, 6'd4, NOP,      6'd4, 1'b1, 16'd4};
        tbl[6]  = '{1'b0, 1'b0, 6'd5, NOP,      6'd5, 1'b1, 16'd5};
        tbl[7]  = '{1'b0, 1'b1, 6'd5, NOP,      6'd5, 1'b1, 16'd5};
        tbl[8]  = '{1'b0, 1'b1, 6'd5, NOP,      6'd5, 1'b1, 16'd5};
        tbl[9]  = '{1'b0, 1'b1, 6'd5, NOP,      6'd5, 1'b1, 16'd5};
        tbl[10] = '{1'b0, 1'b0, 6'd6, NOP,      6'd6, 1'b1, 16'd6};
        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].rst, tbl[i].stall, 1'b0, 6'd0);
            chk($sformatf("tbl%0d_pc", i), {10'd0, fif.pc}, {10'd0, tbl[i].pc});
            chk($sformatf("tbl%0d_instr", i), fif.ifid_instr, tbl[i].instr);
            chk($sformatf("tbl%0d_ifpc", i), {10'd0, fif.ifid_pc}, {10'd0, tbl[i].ifpc});
            chk($sformatf("tbl%0d_valid", i), {15'd0, fif.ifid_valid}, {15'd0, tbl[i].valid});
            chk($sformatf("tbl%0d_cnt", i), fif.fetch_cnt, tbl[i].cnt);
        end

        // free run across the PC wrap
        tick(1'b1, 1'b0, 1'b0, 6'd0);
        tick(1'b0, 1'b0, 1'b0, 6'd0);
        seen63 = 1'b0;
        wrapped = 1'b0;
        for (int i = 0; i < 69; i++) begin
            run(1);
            if (fif.ifid_pc == 6'd63) seen63 = 1'b1;
            if (seen63 && fif.ifid_pc == 6'd0) wrapped = 1'b1;
        end
        chk("wrap_seen", {15'd0, wrapped}, 16'd1);
        chk("wrap_cnt", fif.fetch_cnt, 16'd69);
        chk("wrap_pc", {10'd0, fif.pc}, 16'd5);

        // taken branch at PC=7
        mem[7] = 16'h1234;
        tick(1'b1, 1'b0, 1'b0, 6'd0);
        tick(1'b0, 1'b0, 1'b0, 6'd0);
        run(7);
        tick(1'b0, 1'b0, 1'b1, 6'd1);
        chk("br_pc", {10'd0, fif.pc}, 16'd1);
        chk("br_instr", fif.ifid_instr, FLUSH ? NOP : 16'h1234);
        chk("br_valid", {15'd0, fif.ifid_valid}, FLUSH ? 16'd0 : 16'd1);
        chk("br_cnt", fif.fetch_cnt, FLUSH ? 16'd7 : 16'd8);

        // stall and branch together: branch wins, next edge fetches address 3
        tick(1'b0, 1'b1, 1'b1, 6'd3);
        chk("sb_pc", {10'd0, fif.pc}, 16'd3);
        tick(1'b0, 1'b0, 1'b0, 6'd0);
        chk("sb_next_ifpc", {10'd0, fif.ifid_pc}, 16'd4);

        // reset in the middle of a stall with a branch pending
        tick(1'b0, 1'b1, 1'b0, 6'd0);
        tick(1'b1, 1'b1, 1'b1, 6'd9);
        chk("rst_valid", {15'd0, fif.ifid_valid}, 16'd0);
        tick(1'b0, 1'b1, 1'b1, 6'd9);
        chk("rst_boot_pc", {10'd0, fif.pc}, 16'd0);
        tick(1'b0, 1'b0, 1'b0, 6'd0);
        chk("rst_first_instr", fif.ifid_instr, 16'h2213);

        // randomized traffic with random memory contents
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 6'($urandom_range(0, 63)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
